// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind spi_slave: executes decoded frames against an LED register bank.
// Fixed 4-cycle pass per frame (IDLE->DECODE->EXEC->RESP); frames arriving while busy are dropped and counted.
module spi_cmd_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int FRAME_W  = 24
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  frm_vld,
  input  logic [7:0]            i_cmd,
  input  logic [7:0]            i_addr,
  input  logic [7:0]            i_payload,
  output logic [FRAME_W-1:0]    o_rsp_frame,
  output logic                  o_rsp_vld,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic [NUM_REGS-1:0]   o_reg_upd,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt,
  output logic                  o_ovr
);

  localparam logic [7:0] CMD_WRITE   = 8'h80;
  localparam logic [7:0] CMD_READ    = 8'h40;
  localparam logic [7:0] CMD_STATUS  = 8'hC0;
  localparam logic [7:0] CMD_CLR_ERR = 8'h20;
  localparam logic [7:0] RSP_ERR     = 8'hEE;
  localparam logic [8:0] NUM_REGS_W  = 9'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
  typedef enum logic [2:0] {OP_WRITE, OP_READ, OP_STATUS, OP_CLR, OP_ERR} op_t;

  state_t                 state, state_nxt;
  op_t                    op_q, op_dec;
  logic [7:0]             cmd_q, addr_q, pay_q, code_q, code_dec;
  logic [NUM_REGS*8-1:0]  regs_q;
  logic                   addr_ok, drop, wr_en, clr_en, err_en;
  logic [7:0]             rd_data, err_base, err_nxt;
  logic [8:0]             err_sum;
  logic                   ovr_nxt;
  logic [NUM_REGS-1:0]    upd_nxt;
  logic [FRAME_W-1:0]     rsp_nxt;

  assign o_regs = regs_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (frm_vld) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != IDLE);
    drop     = frm_vld && (state != IDLE);
    addr_ok  = ({1'b0, addr_q} < NUM_REGS_W);

    op_dec   = OP_ERR;
    code_dec = 8'h01;
    case (cmd_q)
      CMD_WRITE:   begin op_dec = addr_ok ? OP_WRITE : OP_ERR; code_dec = 8'h02; end
      CMD_READ:    begin op_dec = addr_ok ? OP_READ  : OP_ERR; code_dec = 8'h02; end
      CMD_STATUS:  op_dec = OP_STATUS;
      CMD_CLR_ERR: op_dec = OP_CLR;
      default:     op_dec = OP_ERR;
    endcase

    rd_data = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr_q == 8'(k)) rd_data = regs_q[8*k +: 8];

    wr_en  = (state == EXEC) && (op_q == OP_WRITE);
    clr_en = (state == EXEC) && (op_q == OP_CLR);
    err_en = (state == EXEC) && (op_q == OP_ERR);

    upd_nxt = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (wr_en && addr_q == 8'(k)) upd_nxt[k] = 1'b1;

    case (op_q)
      OP_WRITE:  rsp_nxt = {CMD_WRITE, addr_q, pay_q};
      OP_READ:   rsp_nxt = {CMD_READ, addr_q, rd_data};
      OP_STATUS: rsp_nxt = {CMD_STATUS, 7'b0, o_ovr, o_err_cnt};
      OP_CLR:    rsp_nxt = {CMD_CLR_ERR, addr_q, o_err_cnt};
      default:   rsp_nxt = {RSP_ERR, addr_q, code_q};
    endcase

    // A drop coinciding with a clear is applied after the clear, so it survives.
    err_base = clr_en ? 8'h00 : o_err_cnt;
    err_sum  = {1'b0, err_base} + 9'(err_en) + 9'(drop);
    err_nxt  = err_sum[8] ? 8'hFF : err_sum[7:0];
    ovr_nxt  = drop | (o_ovr & ~clr_en);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      pay_q       <= '0;
      op_q        <= OP_ERR;
      code_q      <= '0;
      regs_q      <= '0;
      o_reg_upd   <= '0;
      o_rsp_vld   <= 1'b0;
      o_rsp_frame <= '0;
      o_err_cnt   <= '0;
      o_ovr       <= 1'b0;
    end else begin
      if (state == IDLE && frm_vld) begin
        cmd_q  <= i_cmd;
        addr_q <= i_addr;
        pay_q  <= i_payload;
      end
      if (state == DECODE) begin
        op_q   <= op_dec;
        code_q <= code_dec;
      end
      for (int k = 0; k < NUM_REGS; k++)
        if (upd_nxt[k]) regs_q[8*k +: 8] <= pay_q;
      o_reg_upd <= upd_nxt;
      o_rsp_vld <= (state == EXEC);
      if (state == EXEC) o_rsp_frame <= rsp_nxt;
      o_err_cnt <= err_nxt;
      o_ovr     <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed vector table, hand corner sequences, then random frames against a frame-level model.
module tb_spi_cmd_ctrl;
  localparam int NR = 4;

  logic          sysclk = 0;
  logic          rst_n;
  logic          frm_vld;
  logic [7:0]    i_cmd, i_addr, i_payload;
  logic [23:0]   o_rsp_frame;
  logic          o_rsp_vld;
  logic [NR*8-1:0] o_regs;
  logic [NR-1:0] o_reg_upd;
  logic          o_busy;
  logic [7:0]    o_err_cnt;
  logic          o_ovr;

  spi_cmd_ctrl #(.NUM_REGS(NR), .FRAME_W(24)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .frm_vld(frm_vld),
    .i_cmd(i_cmd), .i_addr(i_addr), .i_payload(i_payload),
    .o_rsp_frame(o_rsp_frame), .o_rsp_vld(o_rsp_vld), .o_regs(o_regs),
    .o_reg_upd(o_reg_upd), .o_busy(o_busy), .o_err_cnt(o_err_cnt), .o_ovr(o_ovr)
  );

  always #4 sysclk = ~sysclk;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  // Model: the frame accepted at slot k executes at slot k+2 and is visible at slot k+3.
  typedef struct { int tm; logic [23:0] f; } exp_t;
  exp_t        expq[$];
  logic [7:0]  m_regs [NR];
  int          m_err;
  bit          m_ovr;
  logic [NR-1:0] m_upd;
  logic [23:0] m_frame;
  bit          pend;
  int          pend_e;
  logic [7:0]  p_cmd, p_addr, p_pay;
  int          last_acc;
  int          t = 0;

  typedef struct {
    logic [7:0]  c, a, p;
    logic [23:0] rsp;
    logic [7:0]  err;
    logic [31:0] regs;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_err = 0; m_ovr = 0; m_upd = '0; m_frame = '0;
    pend = 0; last_acc = -100;
    expq.delete();
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_exec();
    exp_t e;
    bit ok;
    ok = (p_addr < NR);
    e.tm = t + 1;
    if (p_cmd == 8'h80 && ok) begin
      e.f = {8'h80, p_addr, p_pay};
      m_regs[p_addr] = p_pay;
      m_upd[p_addr] = 1'b1;
    end else if (p_cmd == 8'h40 && ok) begin
      e.f = {8'h40, p_addr, m_regs[p_addr]};
    end else if (p_cmd == 8'hC0) begin
      e.f = {8'hC0, 7'b0, m_ovr, 8'(m_err)};
    end else if (p_cmd == 8'h20) begin
      e.f = {8'h20, p_addr, 8'(m_err)};
      m_err = 0; m_ovr = 0;
    end else begin
      e.f = {8'hEE, p_addr, (p_cmd == 8'h80 || p_cmd == 8'h40) ? 8'h02 : 8'h01};
      m_err = sat(m_err + 1);
    end
    expq.push_back(e);
  endtask

  // One cycle: check DUT against model, advance model, drive this slot's inputs.
  task automatic step(input bit f, input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    bit exp_vld;
    logic [31:0] exp_regs;
    @(negedge sysclk);
    t++;
    exp_vld = (expq.size() > 0) && (expq[0].tm == t);
    if (o_rsp_vld) pulses++;
    if (exp_vld || o_rsp_vld) chk("rsp_vld", 32'(o_rsp_vld), 32'(exp_vld));
    if (exp_vld) begin
      m_frame = expq[0].f;
      void'(expq.pop_front());
    end
    chk("rsp_frame", 32'(o_rsp_frame), 32'(m_frame));
    for (int i = 0; i < NR; i++) exp_regs[8*i +: 8] = m_regs[i];
    chk("regs", o_regs, exp_regs);
    chk("reg_upd", 32'(o_reg_upd), 32'(m_upd));
    chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
    chk("ovr", 32'(o_ovr), 32'(m_ovr));
    chk("busy", 32'(o_busy), 32'((t > last_acc) && (t <= last_acc + 3)));
    m_upd = '0;
    if (pend && pend_e == t) begin
      model_exec();
      pend = 0;
    end
    frm_vld = f; i_cmd = c; i_addr = a; i_payload = p;
    if (f) begin
      if (t <= last_acc + 3) begin
        m_err = sat(m_err + 1);
        m_ovr = 1;
      end else begin
        last_acc = t; pend = 1; pend_e = t + 2;
        p_cmd = c; p_addr = a; p_pay = p;
      end
    end
  endtask

  task automatic idle();
    step(0, 8'h00, 8'h00, 8'h00);
  endtask

  // Issue a frame and return in its response cycle (N+3).
  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    step(1, c, a, p);
    repeat (3) idle();
  endtask

  task automatic do_reset();
    frm_vld = 0; i_cmd = 0; i_addr = 0; i_payload = 0;
    rst_n = 0;
    #1;
    chk("rst_rsp_vld", 32'(o_rsp_vld), 0);
    chk("rst_frame", 32'(o_rsp_frame), 0);
    chk("rst_regs", o_regs, 0);
    chk("rst_busy_err_ovr", {o_busy, o_err_cnt, o_ovr, o_reg_upd}, 0);
    model_clear();
    repeat (2) @(negedge sysclk);
    rst_n = 1;
  endtask

  initial begin
    vecs[0] = '{8'h80, 8'h02, 8'hD0, 24'h8002D0, 8'd0, 32'h00D0_0000};
    vecs[1] = '{8'h40, 8'h02, 8'h00, 24'h4002D0, 8'd0, 32'h00D0_0000};
    vecs[2] = '{8'h13, 8'h00, 8'h00, 24'hEE0001, 8'd1, 32'h00D0_0000};
    vecs[3] = '{8'h80, 8'h05, 8'hFF, 24'hEE0502, 8'd2, 32'h00D0_0000};
    vecs[4] = '{8'hC0, 8'h00, 8'h00, 24'hC00002, 8'd2, 32'h00D0_0000};
    vecs[5] = '{8'h20, 8'h07, 8'h00, 24'h200702, 8'd0, 32'h00D0_0000};
    vecs[6] = '{8'h40, 8'h09, 8'h00, 24'hEE0902, 8'd1, 32'h00D0_0000};
    vecs[7] = '{8'h80, 8'h00, 8'h11, 24'h800011, 8'd1, 32'h00D0_0011};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].c, vecs[i].a, vecs[i].p);
      chk($sformatf("vec%0d_vld", i), 32'(o_rsp_vld), 1);
      chk($sformatf("vec%0d_frame", i), 32'(o_rsp_frame), 32'(vecs[i].rsp));
      chk($sformatf("vec%0d_err", i), 32'(o_err_cnt), 32'(vecs[i].err));
      chk($sformatf("vec%0d_regs", i), o_regs, vecs[i].regs);
      if (i == 0) chk("vec0_upd", 32'(o_reg_upd), 32'h4);
    end

    // Busy drop during EXEC, then STATUS and CLR_ERR.
    do_reset();
    pulses = 0;
    step(1, 8'h80, 8'h01, 8'hAA); idle(); step(1, 8'h40, 8'h00, 8'h00); idle();
    chk("drop_frame", 32'(o_rsp_frame), 32'h8001AA);
    chk("drop_err", 32'(o_err_cnt), 1);
    chk("drop_ovr", 32'(o_ovr), 1);
    repeat (4) idle();
    chk("drop_pulses", pulses, 1);
    send(8'hC0, 8'h00, 8'h00);
    chk("status_frame", 32'(o_rsp_frame), 32'hC00101);
    send(8'h20, 8'h00, 8'h00);
    chk("clr_frame", 32'(o_rsp_frame), 32'h200001);
    chk("clr_err_ovr", {o_err_cnt, 7'b0, o_ovr}, 0);

    // Drop coinciding with CLR_ERR, then with an error.
    send(8'h13, 8'h00, 8'h00);
    step(1, 8'h20, 8'h00, 8'h00); idle(); step(1, 8'h13, 8'h00, 8'h00); idle();
    chk("clrdrop_frame", 32'(o_rsp_frame), 32'h200001);
    chk("clrdrop_err", 32'(o_err_cnt), 1);
    chk("clrdrop_ovr", 32'(o_ovr), 1);
    step(1, 8'h13, 8'h00, 8'h00); idle(); step(1, 8'h13, 8'h00, 8'h00); idle();
    chk("errdrop_err", 32'(o_err_cnt), 3);

    // Saturation.
    for (int i = 0; i < 300; i++) send(8'h13, 8'h00, 8'h00);
    chk("sat_err", 32'(o_err_cnt), 32'hFF);
    send(8'h55, 8'h01, 8'h00);
    chk("sat_hold", 32'(o_err_cnt), 32'hFF);

    // Reset in the middle of a WRITE.
    do_reset();
    step(1, 8'h80, 8'h01, 8'h55); idle();
    @(negedge sysclk);
    frm_vld = 0;
    rst_n = 0;
    #1;
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_regs", o_regs, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      chk("midrst_no_rsp", 32'(o_rsp_vld), 0);
    end
    model_clear();
    rst_n = 1;
    repeat (3) idle();
    send(8'h80, 8'h03, 8'h77);
    chk("postrst_frame", 32'(o_rsp_frame), 32'h800377);
    chk("postrst_regs", o_regs, 32'h7700_0000);

    // Random frames with random spacing (some dropped).
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] c;
      int gap;
      gap = $urandom_range(0, 6);
      repeat (gap) idle();
      case ($urandom_range(0, 5))
        0: c = 8'h80;
        1: c = 8'h40;
        2: c = 8'hC0;
        3: c = 8'h20;
        4: c = 8'($urandom);
        default: c = 8'h80;
      endcase
      step(1, c, 8'($urandom_range(0, 5)), 8'($urandom));
    end
    repeat (6) idle();
    chk("rand_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind spi_slave. It takes each decoded 24-bit frame (cmd/addr/payload) and executes it against a small LED brightness register bank. It then builds the response frame that spi_slave shifts out on MISO during the next transaction. It also tracks protocol errors and dropped frames for the top level.

Parameters:
NUM_REGS, 4, number of 8-bit brightness registers; legal addresses are 0..NUM_REGS-1; range 1..16.
FRAME_W, 24, frame width; fixed as CMD_BITS + ADDR_BITS + PAYLOAD_BITS (8+8+8).

Ports:
sysclk  in  1  system clock, 125 MHz.
rst_n  in  1  asynchronous, active-low reset.
frm_vld  in  1  one-sysclk strobe from the slave side; i_cmd/i_addr/i_payload are valid in that cycle.
i_cmd  in  8  command byte.
i_addr  in  8  address byte.
i_payload  in  8  payload byte.
o_rsp_frame  out  24  response frame to the slave's transmit frame input.
o_rsp_vld  out  1  one-cycle strobe to the slave's transmit enable.
o_regs  out  NUM_REGS*8  flattened register bank; reg k occupies bits [8k+7:8k].
o_reg_upd  out  NUM_REGS  one-cycle strobe per register on write.
o_busy  out  1  high whenever state != IDLE.
o_err_cnt  out  8  saturating error counter.
o_ovr  out  1  sticky dropped-frame flag.

Behaviour:
- Reset: async on rst_n low. All outputs are 0, all registers are 0, and state is IDLE. This applies at any point, including mid-sequence; no response is emitted for an interrupted frame.
- Capture: in IDLE, frm_vld=1 latches cmd/addr/payload at cycle N. State moves to DECODE at N+1.
- FSM: IDLE -> DECODE (N+1) -> EXEC (N+2) -> RESP (N+3) -> IDLE (N+4). There are no other transitions except reset.
- DECODE: classify the latched cmd.
  - 0x80 WRITE, 0x40 READ, 0xC0 STATUS, 0x20 CLR_ERR.
  - Any other value is error code 0x01.
  - WRITE or READ with addr >= NUM_REGS is error code 0x02.
- EXEC:
  - WRITE: reg[addr] <= payload. The new value is visible on o_regs at N+3, and o_reg_upd[addr]=1 for the single cycle N+3.
  - CLR_ERR: err_cnt <= 0, and o_ovr is cleared.
  - READ, STATUS and errors make no register change.
  - An error increments err_cnt, saturating at 0xFF.
- RESP: o_rsp_vld=1 for exactly cycle N+3. o_rsp_frame is updated at N+3 and holds until the next RESP or reset. Frame contents:
  - WRITE: {0x80, addr, payload}, an echo.
  - READ: {0x40, addr, reg[addr]}.
  - STATUS: {0xC0, {7'b0, o_ovr}, err_cnt}.
  - CLR_ERR: {0x20, addr, err_cnt value before clearing}.
  - Error: {0xEE, addr, code}.
- Busy drop: frm_vld=1 while state != IDLE means the frame is discarded. Then o_ovr is set to 1 and err_cnt increments (saturating). There is no response and the FSM is undisturbed.
- Simultaneous events:
  - A drop in the same cycle as an EXEC error adds 2, saturating at 0xFF.
  - A drop in the same cycle as an EXEC CLR_ERR gives err_cnt = 1 and o_ovr = 1; the drop wins over the clear.
- Back-to-back: frm_vld at N+4 or later is accepted. The minimum frame spacing is 4 cycles, far below one SPI frame at 26 MHz (about 115 sysclk).
- Saturation: err_cnt never wraps; at 0xFF further errors leave it at 0xFF.

Test Plan:
- Reset, then frm_vld with {0x80,0x02,0xD0} -> at N+3: o_regs[23:16]=0xD0, o_reg_upd=4'b0100, o_rsp_vld=1, o_rsp_frame=0x8002D0; other registers remain 0.
- READ {0x40,0x02,0x00} after the above write -> o_rsp_frame=0x4002D0 at N+3; o_regs unchanged; o_reg_upd=0.
- Bad cmd {0x13,0x00,0x00}, then addr out of range {0x80,0x05,0xFF} -> responses 0xEE0001 and 0xEE0502; err_cnt=2; no register written.
- frm_vld at N and again at N+2 -> the second frame is dropped; o_ovr=1; err_cnt=1; exactly one o_rsp_vld pulse. STATUS then returns 0xC00101, and CLR_ERR returns 0x200001 with err_cnt=0 and o_ovr=0 afterwards.
- 300 bad commands -> err_cnt reads 0xFF and stays there.
- Issue WRITE {0x80,0x01,0x55} and assert rst_n=0 at N+2 -> immediately: o_busy=0, o_regs=0, o_rsp_vld never pulses. After release, a new WRITE completes normally.
